// File: rtl/pipelined_rca_pkg.sv
// rtl/pipelined_rca_pkg.sv - shared types and helpers for the pipelined ripple-carry adder
package pipelined_rca_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } rca_flags_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Returns {carry_out, sum} of a single full-adder cell.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CHUNK-bit ripple adder built from full-adder cells
module rca_chunk
    import pipelined_rca_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    always_comb begin
        logic       carry;
        logic [1:0] fa;
        carry  = c_i;
        fa     = '0;
        sum_o  = '0;
        cmsb_o = c_i;
        for (int i = 0; i < CHUNK; i++) begin
            cmsb_o   = carry;
            fa       = full_add(a_i[i], b_i[i], carry);
            sum_o[i] = fa[0];
            carry    = fa[1];
        end
        cout_o = carry;
    end

endmodule

// File: rtl/pipelined_rca.sv
// rtl/pipelined_rca.sv - STAGES-deep pipelined add/subtract unit with valid/ready on both sides
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_rca: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] free, load, adv;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [CHUNK-1:0]  op_a  [STAGES];
    logic [CHUNK-1:0]  op_b  [STAGES];
    logic [CHUNK-1:0]  chunk_sum [STAGES];
    logic [STAGES-1:0] chunk_cin, chunk_cout, chunk_cmsb;
    logic [WIDTH-1:0]  b_eff;
    rca_flags_t        flags_q, flags_d;

    assign b_eff = b ^ {WIDTH{op_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        // A stage can take a new beat unless it and every stage after it are full and the output is stalled.
        assign free[k]    = out_ready | ~(&valid_q[STAGES-1:k]);
        assign valid_d[k] = load[k] | (valid_q[k] & ~adv[k]);

        if (k == STAGES - 1) begin : g_last_adv
            assign adv[k] = valid_q[k] & out_ready;
        end else begin : g_mid_adv
            assign adv[k] = valid_q[k] & free[k+1];
        end

        if (k == 0) begin : g_first
            assign load[k]      = in_valid & free[k];
            assign op_a[k]      = a[CHUNK-1:0];
            assign op_b[k]      = b_eff[CHUNK-1:0];
            assign chunk_cin[k] = cin;
            assign a_d[k]       = a;
            assign b_d[k]       = b_eff;
        end else begin : g_next
            assign load[k]      = valid_q[k-1] & free[k];
            assign op_a[k]      = a_q[k-1][LO +: CHUNK];
            assign op_b[k]      = b_q[k-1][LO +: CHUNK];
            assign chunk_cin[k] = carry_q[k-1];
            assign a_d[k]       = a_q[k-1];
            assign b_d[k]       = b_q[k-1];
        end

        if (k == 0 && STAGES == 1) begin : g_sum_only
            assign sum_d[k] = chunk_sum[k];
        end else if (k == 0) begin : g_sum_first
            assign sum_d[k] = {{(WIDTH-CHUNK){1'b0}}, chunk_sum[k]};
        end else if (k == STAGES - 1) begin : g_sum_last
            assign sum_d[k] = {chunk_sum[k], sum_q[k-1][LO-1:0]};
        end else begin : g_sum_mid
            assign sum_d[k] = {sum_q[k-1][WIDTH-1:HI], chunk_sum[k], sum_q[k-1][LO-1:0]};
        end

        rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_i    (op_a[k]),
            .b_i    (op_b[k]),
            .c_i    (chunk_cin[k]),
            .sum_o  (chunk_sum[k]),
            .cout_o (chunk_cout[k]),
            .cmsb_o (chunk_cmsb[k])
        );
    end

    always_comb begin
        flags_d      = '0;
        flags_d.cout = chunk_cout[STAGES-1];
        flags_d.ovf  = chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
        flags_d.zero = (sum_d[STAGES-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    sum_q[k]   <= sum_d[k];
                    a_q[k]     <= a_d[k];
                    b_q[k]     <= b_d[k];
                    carry_q[k] <= chunk_cout[k];
                end
            end
            if (load[STAGES-1]) begin
                flags_q <= flags_d;
            end
        end
    end

    assign in_ready  = free[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_rca.sv
// tb/tb_pipelined_rca.sv - self-checking bench for pipelined_rca across four WIDTH/STAGES configurations
module tb_pipelined_rca;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          t_acc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        op_sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;

    logic [3:0]  iv_v, ir_v, ov_v, c_v, v_v, z_v;
    logic [7:0]  s0;
    logic [31:0] s1, s2;
    logic [15:0] s3;

    logic [31:0] sum_s;
    logic        ir_s, ov_s, c_s, v_s, z_s;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    n_acc = 0;
    bit    lat_chk = 0;
    bit    saw_block = 0;
    beat_t sb[$];

    assign iv_v = in_valid ? 4'(4'b0001 << sel) : 4'b0000;

    pipelined_rca #(.WIDTH(8), .STAGES(2)) u_dut_8x2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .op_sub(op_sub),
        .out_valid(ov_v[0]), .out_ready(out_ready), .sum(s0),
        .cout(c_v[0]), .ovf(v_v[0]), .zero(z_v[0])
    );

    pipelined_rca #(.WIDTH(32), .STAGES(4)) u_dut_32x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(ov_v[1]), .out_ready(out_ready), .sum(s1),
        .cout(c_v[1]), .ovf(v_v[1]), .zero(z_v[1])
    );

    pipelined_rca #(.WIDTH(32), .STAGES(1)) u_dut_32x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[2]), .in_ready(ir_v[2]),
        .a(a), .b(b), .cin(cin), .op_sub(op_sub),
        .out_valid(ov_v[2]), .out_ready(out_ready), .sum(s2),
        .cout(c_v[2]), .ovf(v_v[2]), .zero(z_v[2])
    );

    pipelined_rca #(.WIDTH(16), .STAGES(16)) u_dut_16x16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_v[3]), .in_ready(ir_v[3]),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .op_sub(op_sub),
        .out_valid(ov_v[3]), .out_ready(out_ready), .sum(s3),
        .cout(c_v[3]), .ovf(v_v[3]), .zero(z_v[3])
    );

    always_comb begin
        case (sel)
            2'd0:    sum_s = {24'b0, s0};
            2'd1:    sum_s = s1;
            2'd2:    sum_s = s2;
            default: sum_s = {16'b0, s3};
        endcase
        ir_s = ir_v[sel];
        ov_s = ov_v[sel];
        c_s  = c_v[sel];
        v_s  = v_v[sel];
        z_s  = z_v[sel];
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int width_of(input logic [1:0] s);
        case (s)
            2'd0:    return 8;
            2'd3:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int stages_of(input logic [1:0] s);
        case (s)
            2'd0:    return 2;
            2'd1:    return 4;
            2'd2:    return 1;
            default: return 16;
        endcase
    endfunction

    // Reference: plain modular arithmetic; overflow from operand/result signs.
    function automatic beat_t model(input beat_t t, input int w);
        logic [32:0] mask, aa, bb, full, s;
        mask    = (33'd1 << w) - 33'd1;
        aa      = {1'b0, t.a} & mask;
        bb      = (t.sub ? ~{1'b0, t.b} : {1'b0, t.b}) & mask;
        full    = aa + bb + {32'b0, t.cin};
        s       = full & mask;
        t.s     = s[31:0];
        t.c     = full[w];
        t.z     = (s == 33'd0);
        t.v     = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return t;
    endfunction

    function automatic beat_t mk(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                                 input logic sb_, input logic [31:0] s, input logic c,
                                 input logic v, input logic z);
        beat_t t;
        t.a = av; t.b = bv; t.cin = ci; t.sub = sb_;
        t.s = s; t.c = c; t.v = v; t.z = z; t.t_acc = 0;
        return t;
    endfunction

    function automatic beat_t rnd_beat(input int w);
        beat_t t;
        t.a     = $urandom;
        t.b     = $urandom;
        if ($urandom_range(0, 7) == 0) t.b = t.a;
        t.cin   = 1'($urandom_range(0, 1));
        t.sub   = 1'($urandom_range(0, 1));
        t.t_acc = 0;
        return model(t, w);
    endfunction

    task automatic drive_cycle(input logic iv, input beat_t bt, input logic orr);
        beat_t e;
        @(negedge clk);
        in_valid  = iv;
        a         = bt.a;
        b         = bt.b;
        cin       = bt.cin;
        op_sub    = bt.sub;
        out_ready = orr;
        #1;
        checks++;
        if (ir_s !== ((sb.size() < stages_of(sel)) || orr)) begin
            errors++;
            $display("FAIL in_ready: got %b required %b (occupancy %0d, out_ready %b)",
                     ir_s, ((sb.size() < stages_of(sel)) || orr), sb.size(), orr);
        end
        if (ov_s !== 1'b0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_beat: out_valid=%b sum=%h with nothing in flight", ov_s, sum_s);
            end else begin
                e = sb[0];
                if (sum_s !== e.s || c_s !== e.c || v_s !== e.v || z_s !== e.z) begin
                    errors++;
                    $display("FAIL result: got sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                             sum_s, c_s, v_s, z_s, e.s, e.c, e.v, e.z);
                end
                if (orr) begin
                    e = sb.pop_front();
                    if (lat_chk) begin
                        checks++;
                        if (cyc - e.t_acc != stages_of(sel)) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles required %0d", cyc - e.t_acc, stages_of(sel));
                        end
                    end
                end
            end
        end
        saw_block = saw_block | (iv && !ir_s);
        if (iv && ir_s) begin
            bt.t_acc = cyc;
            sb.push_back(bt);
            n_acc++;
        end
    endtask

    task automatic drain();
        beat_t idle;
        idle = mk(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400 && sb.size() > 0; i++) drive_cycle(1'b0, idle, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, idle, 1'b1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats never emerged, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            checks++;
            if (ov_s !== 1'b0 || sum_s !== 32'h0 || {c_s, v_s, z_s} !== 3'b000 || ir_s !== 1'b1) begin
                errors++;
                $display("FAIL reset_state dut%0d: got ov=%b sum=%h cvz=%b%b%b ir=%b required 0/0/000/1",
                         i, ov_s, sum_s, c_s, v_s, z_s, ir_s);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        beat_t tbl[8];
        tbl[0] = mk(32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0);
        tbl[1] = mk(32'h55, 32'hAA, 1'b0, 1'b0, 32'hFF, 1'b0, 1'b0, 1'b0);
        tbl[2] = mk(32'h55, 32'hAA, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1);
        tbl[3] = mk(32'h72, 32'h27, 1'b0, 1'b0, 32'h99, 1'b0, 1'b1, 1'b0);
        tbl[4] = mk(32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
        tbl[5] = mk(32'h72, 32'h27, 1'b1, 1'b1, 32'h4B, 1'b1, 1'b0, 1'b0);
        tbl[6] = mk(32'h27, 32'h72, 1'b1, 1'b1, 32'hB5, 1'b0, 1'b0, 1'b0);
        tbl[7] = mk(32'h80, 32'h08, 1'b0, 1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        sel     = 2'd0;
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, tbl[i], 1'b1);
        drain();
        lat_chk = 1'b0;
    endtask

    task automatic test_backpressure();
        int start, i;
        sel       = 2'd1;
        saw_block = 1'b0;
        start     = n_acc;
        i         = 0;
        while (n_acc - start < 6 && i < 60) begin
            drive_cycle(1'b1, rnd_beat(32), !(i >= 2 && i < 6));
            i++;
        end
        drain();
        checks++;
        if (n_acc - start != 6) begin
            errors++;
            $display("FAIL backpressure_accept: got %0d beats accepted required 6", n_acc - start);
        end
        checks++;
        if (!saw_block) begin
            errors++;
            $display("FAIL backpressure_block: in_ready never dropped, required a drop with full pipe");
        end
    endtask

    task automatic test_reset_midflight();
        beat_t idle;
        idle = mk(32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        sel = 2'd0;
        drive_cycle(1'b1, mk(32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1), 1'b0);
        drive_cycle(1'b1, mk(32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0), 1'b0);
        drive_cycle(1'b0, idle, 1'b0);
        checks++;
        if (ov_s !== 1'b1) begin
            errors++;
            $display("FAIL midflight_setup: out_valid=%b required 1 before reset", ov_s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov_s !== 1'b0 || sum_s !== 32'h0 || {c_s, v_s, z_s} !== 3'b000 || ir_s !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset: got ov=%b sum=%h cvz=%b%b%b ir=%b required 0/0/000/1",
                     ov_s, sum_s, c_s, v_s, z_s, ir_s);
        end
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive_cycle(1'b1, mk(32'h72, 32'h27, 1'b1, 1'b1, 32'h4B, 1'b1, 1'b0, 1'b0), 1'b1);
        drain();
    endtask

    task automatic test_random_sweep(input logic [1:0] s, input int nbeats);
        int start, i;
        sel   = s;
        start = n_acc;
        i     = 0;
        while (n_acc - start < nbeats && i < 10 * nbeats) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), rnd_beat(width_of(s)),
                        1'($urandom_range(0, 3) != 0));
            i++;
        end
        drain();
        checks++;
        if (n_acc - start != nbeats) begin
            errors++;
            $display("FAIL sweep_dut%0d: got %0d beats accepted required %0d", s, n_acc - start, nbeats);
        end
    endtask

    initial begin
        sel = 2'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random_sweep(2'd1, 1000);
        test_random_sweep(2'd2, 1000);
        test_random_sweep(2'd3, 1000);
        test_random_sweep(2'd0, 500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
